// File: rtl/uart_host_ctrl.sv
// rtl/uart_host_ctrl.sv - register-bus initiator that initialises and services a UART register block
// Turns the UART's 8-bit register bus into byte-wide tx/rx valid/ready streams; no CPU involvement.
module uart_host_ctrl #(
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  FCR_VAL  = 8'hC6,
    parameter int          TX_BURST = 16,
    parameter int          POLL_GAP = 8
) (
    input  logic       clk,
    input  logic       wb_rst_i,
    output logic [2:0] wb_addr_o,
    output logic [7:0] wb_dat_o,
    output logic       wb_we_o,
    output logic       wb_re_o,
    input  logic [7:0] wb_dat_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [3:0] err_o,
    input  logic       err_clr_i,
    output logic       init_done_o
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_TX_WR,
        S_LS_RD,
        S_LS_CAP,
        S_RB_RD,
        S_RB_CAP
    } state_t;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_IE   = 3'd1;
    localparam logic [2:0] ADDR_FC   = 3'd2;
    localparam logic [2:0] ADDR_LC   = 3'd3;
    localparam logic [2:0] ADDR_LS   = 3'd5;
    localparam logic [4:0] CREDIT_FULL = 5'(TX_BURST);
    localparam logic [7:0] GAP_LOAD    = 8'(POLL_GAP);

    state_t     r_state;
    logic [2:0] r_init_idx;
    logic [4:0] r_credit;
    logic [7:0] r_gap;
    logic [2:0] r_addr;
    logic [7:0] r_dat;
    logic       r_we;
    logic       r_re;
    logic       r_tx_ready;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic [3:0] r_err;
    logic       r_init_done;

    logic [2:0] w_init_addr;
    logic [7:0] w_init_dat;
    logic [4:0] w_cap_credit;

    // Divisor latch is reached through TR/IE while DLAB is set by the first write.
    always_comb begin
        w_init_addr = ADDR_IE;
        w_init_dat  = 8'h00;
        case (r_init_idx)
            3'd0: begin w_init_addr = ADDR_LC;   w_init_dat = LCR_VAL | 8'h80; end
            3'd1: begin w_init_addr = ADDR_DATA; w_init_dat = DIVISOR[7:0];    end
            3'd2: begin w_init_addr = ADDR_IE;   w_init_dat = DIVISOR[15:8];   end
            3'd3: begin w_init_addr = ADDR_LC;   w_init_dat = LCR_VAL;         end
            3'd4: begin w_init_addr = ADDR_FC;   w_init_dat = FCR_VAL;         end
            default: begin w_init_addr = ADDR_IE; w_init_dat = 8'h00;          end
        endcase
    end

    assign w_cap_credit = wb_dat_i[5] ? CREDIT_FULL : r_credit;

    always_ff @(posedge clk) begin
        if (!wb_rst_i) begin
            r_state     <= S_INIT;
            r_init_idx  <= 3'd0;
            r_credit    <= 5'd0;
            r_gap       <= GAP_LOAD;
            r_addr      <= 3'd0;
            r_dat       <= 8'h00;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_err       <= 4'd0;
            r_init_done <= 1'b0;
        end else begin
            // Every strobe is single-cycle, so the bus idles unless a branch below drives it.
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_dat  <= 8'h00;
            r_addr <= 3'd0;

            if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end

            if (err_clr_i) begin
                r_err <= 4'd0;
            end else if (r_state == S_LS_CAP) begin
                r_err <= r_err | wb_dat_i[4:1];
            end

            case (r_state)
                S_INIT: begin
                    if (r_init_idx == 3'd6) begin
                        r_init_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_we       <= 1'b1;
                        r_addr     <= w_init_addr;
                        r_dat      <= w_init_dat;
                        r_init_idx <= r_init_idx + 3'd1;
                    end
                end
                S_IDLE: begin
                    if (tx_valid_i && r_tx_ready) begin
                        r_we       <= 1'b1;
                        r_addr     <= ADDR_DATA;
                        r_dat      <= tx_data_i;
                        r_credit   <= (r_credit != 5'd0) ? r_credit - 5'd1 : 5'd0;
                        r_tx_ready <= 1'b0;
                        r_state    <= S_TX_WR;
                    end else if (r_gap == 8'd0 || (r_credit == 5'd0 && tx_valid_i)) begin
                        r_re       <= 1'b1;
                        r_addr     <= ADDR_LS;
                        r_tx_ready <= 1'b0;
                        r_state    <= S_LS_RD;
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                S_TX_WR: begin
                    r_tx_ready <= (r_credit != 5'd0);
                    r_state    <= S_IDLE;
                end
                S_LS_RD: begin
                    r_state <= S_LS_CAP;
                end
                S_LS_CAP: begin
                    r_credit <= w_cap_credit;
                    // A held rx byte masks DR so polling keeps serving TX credit.
                    if (wb_dat_i[0] && !r_rx_valid) begin
                        r_re    <= 1'b1;
                        r_addr  <= ADDR_DATA;
                        r_state <= S_RB_RD;
                    end else begin
                        r_gap      <= GAP_LOAD;
                        r_tx_ready <= (w_cap_credit != 5'd0);
                        r_state    <= S_IDLE;
                    end
                end
                S_RB_RD: begin
                    r_state <= S_RB_CAP;
                end
                S_RB_CAP: begin
                    r_rx_data  <= wb_dat_i;
                    r_rx_valid <= 1'b1;
                    r_gap      <= GAP_LOAD;
                    r_tx_ready <= (r_credit != 5'd0);
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign wb_addr_o   = r_addr;
    assign wb_dat_o    = r_dat;
    assign wb_we_o     = r_we;
    assign wb_re_o     = r_re;
    assign tx_ready_o  = r_tx_ready;
    assign rx_data_o   = r_rx_data;
    assign rx_valid_o  = r_rx_valid;
    assign err_o       = r_err;
    assign init_done_o = r_init_done;

endmodule

// File: doc/uart_host_ctrl.md
# uart_host_ctrl

Register-bus initiator that drives the UART register block's 8-bit bus from the host side. After reset it programs line control, divisor latch and FIFO control. It then polls the line status register, pushes transmit bytes into the transmit holding register and pops received bytes from the receiver buffer. It presents byte-wide valid/ready streams to on-chip logic so no CPU is needed to operate the UART.

## Interface
- DIVISOR, 16'd27, value written to divisor latch (DL2:DL1)
- LCR_VAL, 8'h03, line control value after init (DLAB must be 0; default 8N1)
- FCR_VAL, 8'hC6, FIFO control value written during init (RX trigger 14, both FIFOs reset)
- TX_BURST, 16, THR writes allowed per observed THRE=1 (1..16)
- POLL_GAP, 8, idle cycles between LSR polls (1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-low
- wb_addr_o  out  3  register address (TR/RB=0, IE=1, FC/II=2, LC=3, MC=4, LS=5, MS=6)
- wb_dat_o  out  8  write data
- wb_we_o  out  1  single-cycle write strobe
- wb_re_o  out  1  single-cycle read strobe
- wb_dat_i  in  8  read data, valid the cycle after wb_re_o
- tx_data_i  in  8  byte to transmit
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  byte accepted when tx_valid_i & tx_ready_o
- rx_data_o  out  8  received byte
- rx_valid_o  out  1  rx_data_o valid; held until rx_ready_i
- rx_ready_i  in  1  consumer accepts rx_data_o
- err_o  out  4  sticky {BI,FE,PE,OE} from LSR[4:1]
- err_clr_i  in  1  clears err_o
- init_done_o  out  1  init sequence complete

## Operation
- Reset (wb_rst_i=0 at clk edge): all outputs 0. State goes to INIT with index 0, credit 0 and the gap counter at POLL_GAP. Applies mid-transaction; a strobe in flight is dropped.
- INIT: six writes on consecutive cycles, one per cycle, no reads:
  - LC=LCR_VAL|8'h80
  - TR=DIVISOR[7:0]
  - IE=DIVISOR[15:8]
  - LC=LCR_VAL
  - FC=FCR_VAL
  - IE=8'h00
- After INIT, init_done_o=1 from the next cycle until reset.
- States: INIT, IDLE, TX_WR, LS_RD, LS_CAP, RB_RD, RB_CAP.
- IDLE:
  - tx_ready_o=1 iff credit>0.
  - Handshake: latch tx_data_i, decrement credit and go to TX_WR.
  - Else, gap counter at 0, or credit=0 with tx_valid_i=1: go to LS_RD.
  - Else decrement gap counter.
- TX_WR: wb_we_o=1, addr 0, latched byte. Return to IDLE.
- LS_RD: wb_re_o=1, addr 5.
- LS_CAP: sample wb_dat_i.
  - err_o |= wb_dat_i[4:1].
  - Bit5=1 sets credit to TX_BURST.
  - Bit0=1 with rx_valid_o=0 goes to RB_RD.
  - Otherwise reload gap counter to POLL_GAP and return to IDLE.
- RB_RD: wb_re_o=1, addr 0.
- RB_CAP: rx_data_o=wb_dat_i, rx_valid_o=1. Reload gap, go to IDLE.
- rx_valid_o clears on the cycle after rx_valid_o & rx_ready_i.
- While rx_valid_o=1, DR is ignored and polls continue for TX credit.
- RX read always follows its LSR capture, so RX has priority over a pending TX.
- err_clr_i has priority over a same-cycle set; a set in that cycle is lost.
- Credit is 5 bits and saturates at 0 (never underflows). Gap counter is 8 bits.
- wb_we_o and wb_re_o are never high in the same cycle. wb_dat_o=0 whenever wb_we_o=0.

## Timing
- All outputs registered.
- Init: first write in the first cycle after reset release. init_done_o=1 in cycle 7.
- Write: one strobe cycle; the next bus operation may start the following cycle.
- Read: strobe at cycle N, capture at N+1. The earliest next strobe is N+2.
- TX latency: handshake at cycle T, wb_we_o at T+1.
- RX latency: LSR strobe at N, RB strobe at N+2, rx_valid_o at N+4.
- With credit, sustained TX is one byte per 2 cycles.

## Test plan
- INIT, DIVISOR=16'h0145: writes (3,83),(0,45),(1,01),(3,03),(2,C6),(1,00) in cycles 1-6. init_done_o=1 in cycle 7. No wb_re_o during INIT.
- TX burst, TX_BURST=16, LSR=8'h60, tx_valid_i held with 20 bytes: 16 THR writes with data in order, then an LSR poll. With LSR=8'h00, no further writes until LSR bit5=1.
- RX, LSR=8'h01, RB=8'hA5, rx_ready_i=0: rx_valid_o=1, rx_data_o=A5 held. Subsequent polls issue no RB read. After rx_ready_i pulse, rx_valid_o=0 next cycle.
- Errors, LSR=8'h0A then 8'h10: err_o=4'b0101 then 4'b1101. err_clr_i with a simultaneous LSR=8'h02 capture gives err_o=0.
- Reset mid-TX_WR (wb_rst_i low for 1 cycle): all outputs 0 next cycle. INIT restarts from write 0, and the latched byte is never written.
- DR and pending TX, credit 0, LSR=8'h21: RB read precedes the THR write; the THR write follows within 2 cycles of RB_CAP.
